// File: rtl/hpdcache_arb_req_buf_if.sv
// -----------------------------------------------------------------------------
// hpdcache_arb_req_buf_if
// Bundle of handshake and payload signals around the arbiter payload stage.
//   slave  modport : view of the payload stage itself
//   master modport : view of the surrounding environment
//                    (requesters, arbiter and consumer)
// Signals:
//   req_valid_i / req_ready_o / req_data_i : N requester channels
//   arb_req_o / arb_gnt_i / arb_ready_o    : arbiter request/grant
//   out_valid_o / out_ready_i              : consumer handshake
//   out_data_o / out_id_o                  : consumer payload and requester id
// -----------------------------------------------------------------------------
interface hpdcache_arb_req_buf_if #(
    parameter int N      = 4,
    parameter int DATA_W = 64
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]        req_valid_i;
    logic [N-1:0]        req_ready_o;
    logic [N*DATA_W-1:0] req_data_i;
    logic [N-1:0]        arb_req_o;
    logic [N-1:0]        arb_gnt_i;
    logic                arb_ready_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [DATA_W-1:0]   out_data_o;
    logic [ID_W-1:0]     out_id_o;

    modport slave (
        input  req_valid_i, req_data_i, arb_gnt_i, out_ready_i,
        output req_ready_o, arb_req_o, arb_ready_o,
               out_valid_o, out_data_o, out_id_o
    );

    modport master (
        output req_valid_i, req_data_i, arb_gnt_i, out_ready_i,
        input  req_ready_o, arb_req_o, arb_ready_o,
               out_valid_o, out_data_o, out_id_o
    );
endinterface

// File: rtl/hpdcache_arb_req_buf.sv
// -----------------------------------------------------------------------------
// hpdcache_arb_req_buf
// Payload stage behind a round-robin arbiter. Requester valids are exported as
// arbiter requests; the one-hot grant selects a payload which, with its
// requester index, is pushed into a 2-entry in-order FIFO. The FIFO head drives
// a valid/ready interface to the consumer.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : hpdcache_arb_req_buf_if.slave (requester, arbiter and consumer
//           channels)
// N and DATA_W must match the parameters of the connected interface.
// -----------------------------------------------------------------------------
module hpdcache_arb_req_buf #(
    parameter int N      = 4,
    parameter int DATA_W = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hpdcache_arb_req_buf_if.slave  bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    // Storage and pointers
    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [ID_W-1:0]   id_q   [2];
    logic [ID_W-1:0]   id_d   [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q,  count_d;

    logic              space;
    logic              push;
    logic              pop;
    logic [N-1:0]      req_ready;
    logic [DATA_W-1:0] wr_data;
    logic [ID_W-1:0]   wr_id;

    // Space comes from registered state only: a pop this cycle does not make
    // room for a push in the same cycle.
    assign space = (count_q != 2'd2);

    assign req_ready = bus.arb_gnt_i & bus.req_valid_i & {N{space}};
    assign push      = |req_ready;
    assign pop       = bus.out_valid_o & bus.out_ready_i;

    assign bus.arb_req_o   = bus.req_valid_i;
    assign bus.arb_ready_o = space;
    assign bus.req_ready_o = req_ready;

    // Head of the FIFO straight from storage; no input reaches these outputs.
    assign bus.out_valid_o = (count_q != 2'd0);
    assign bus.out_data_o  = data_q[rd_ptr_q];
    assign bus.out_id_o    = id_q[rd_ptr_q];

    // AND-OR grant mux and binary encode of the grant. A multi-hot grant
    // gives a meaningless payload and is flagged by the assertion below.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        wr_data = '0;
        wr_id   = '0;
        for (int k = 0; k < N; k++) begin
            wr_data |= bus.req_data_i[k*DATA_W +: DATA_W] & {DATA_W{bus.arb_gnt_i[k]}};
            if (bus.arb_gnt_i[k]) begin
                wr_id |= ID_W'(k);
            end
        end
    end

    always_comb begin
        data_d   = data_q;
        id_d     = id_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            data_d[wr_ptr_q] = wr_data;
            id_d[wr_ptr_q]   = wr_id;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the storage entries are reset too, so out_data_o/out_id_o read 0 after reset rather than stale payload.
            data_q   <= '{default: '0};
            id_q     <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
            data_q   <= data_d;
            id_q     <= id_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Simulation checks
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(bus.arb_gnt_i));
    a_count_max : assert property (@(posedge clk_i) disable iff (rst_i)
        count_q <= 2'd2);
    a_push_space : assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> space);

endmodule
